// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Byte-stream program loader. Parses frames of the form
//                0xA5, N[7:0], N[15:8], 4*N little-endian data bytes and
//                writes each assembled 32-bit word into instruction memory
//                through a one-cycle synchronous write strobe. Holds busy
//                while a frame is in progress and reports done / error.
//                Optional macro CSUM_EN adds a trailing XOR checksum byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [7:0] c_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
`ifdef CSUM_EN
        S_CSUM = 3'd4,
`endif
        S_DATA = 3'd3
    } state_t;

    state_t      r_state_q,    w_state_d;
    logic [15:0] r_len_q,      w_len_d;
    logic [15:0] r_word_cnt_q, w_word_cnt_d;
    logic [1:0]  r_byte_idx_q, w_byte_idx_d;
    logic        r_wr_en_q,    w_wr_en_d;
    logic [31:0] r_wr_addr_q,  w_wr_addr_d;
    logic [31:0] r_wr_data_q,  w_wr_data_d;
    logic        r_busy_q,     w_busy_d;
    logic        r_done_q,     w_done_d;
    logic        r_error_q,    w_error_d;
`ifdef CSUM_EN
    logic [7:0]  r_csum_q,     w_csum_d;
`endif

    logic        w_accept;
    logic [15:0] w_len_full;

    // The only stall is the write-strobe cycle; a byte offered then is held.
    assign in_ready   = ~r_wr_en_q;
    assign w_accept   = in_valid & in_ready;
    assign w_len_full = {in_data, r_len_q[7:0]};

    assign wr_en   = r_wr_en_q;
    assign wr_addr = r_wr_addr_q;
    assign wr_data = r_wr_data_q;
    assign busy    = r_busy_q;
    assign done    = r_done_q;
    assign error   = r_error_q;

    // Next-state logic: frame parsing, word assembly and status update.
    always_comb begin
        w_state_d    = r_state_q;
        w_len_d      = r_len_q;
        w_word_cnt_d = r_word_cnt_q;
        w_byte_idx_d = r_byte_idx_q;
        w_wr_en_d    = 1'b0;
        w_wr_addr_d  = r_wr_addr_q;
        w_wr_data_d  = r_wr_data_q;
        w_busy_d     = r_busy_q;
        w_done_d     = r_done_q;
        w_error_d    = r_error_q;
`ifdef CSUM_EN
        w_csum_d     = r_csum_q;
`endif
        if (w_accept) begin
            case (r_state_q)
                S_IDLE: begin
                    // Anything but the sync byte is dropped while idle.
                    if (in_data == c_SYNC_BYTE) begin
                        w_state_d = S_LEN0;
                        w_busy_d  = 1'b1;
                        w_done_d  = 1'b0;
                        w_error_d = 1'b0;
`ifdef CSUM_EN
                        w_csum_d  = 8'h00;
`endif
                    end
                end
                S_LEN0: begin
                    w_len_d[7:0] = in_data;
                    w_state_d    = S_LEN1;
                end
                S_LEN1: begin
                    w_len_d[15:8] = in_data;
                    w_word_cnt_d  = 16'd0;
                    w_byte_idx_d  = 2'd0;
                    if (32'(w_len_full) > MAX_WORDS) begin
                        w_error_d = 1'b1;
                        w_busy_d  = 1'b0;
                        w_state_d = S_IDLE;
                    end else if (w_len_full == 16'd0) begin
`ifdef CSUM_EN
                        w_state_d = S_CSUM;
`else
                        w_done_d  = 1'b1;
                        w_busy_d  = 1'b0;
                        w_state_d = S_IDLE;
`endif
                    end else begin
                        w_state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    // Bytes land directly in their lane; byte 3 completes the word.
                    w_wr_data_d[{r_byte_idx_q, 3'b000} +: 8] = in_data;
                    w_byte_idx_d = r_byte_idx_q + 2'd1;
`ifdef CSUM_EN
                    w_csum_d = r_csum_q ^ in_data;
`endif
                    if (r_byte_idx_q == 2'd3) begin
                        w_wr_en_d    = 1'b1;
                        w_wr_addr_d  = BASE_ADDR + {14'd0, r_word_cnt_q, 2'b00};
                        w_word_cnt_d = r_word_cnt_q + 16'd1;
                        if (r_word_cnt_q == r_len_q - 16'd1) begin
`ifdef CSUM_EN
                            w_state_d = S_CSUM;
`else
                            w_done_d  = 1'b1;
                            w_busy_d  = 1'b0;
                            w_state_d = S_IDLE;
`endif
                        end
                    end
                end
`ifdef CSUM_EN
                S_CSUM: begin
                    if (in_data == r_csum_q) begin
                        w_done_d  = 1'b1;
                    end else begin
                        w_error_d = 1'b1;
                    end
                    w_busy_d  = 1'b0;
                    w_state_d = S_IDLE;
                end
`endif
                default: begin
                    w_state_d = S_IDLE;
                    w_busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; reset drops any partial word or pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= S_IDLE;
            r_len_q      <= 16'd0;
            r_word_cnt_q <= 16'd0;
            r_byte_idx_q <= 2'd0;
            r_wr_en_q    <= 1'b0;
            r_wr_addr_q  <= BASE_ADDR;
            r_wr_data_q  <= 32'd0;
            r_busy_q     <= 1'b0;
            r_done_q     <= 1'b0;
            r_error_q    <= 1'b0;
`ifdef CSUM_EN
            r_csum_q     <= 8'h00;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_len_q      <= w_len_d;
            r_word_cnt_q <= w_word_cnt_d;
            r_byte_idx_q <= w_byte_idx_d;
            r_wr_en_q    <= w_wr_en_d;
            r_wr_addr_q  <= w_wr_addr_d;
            r_wr_data_q  <= w_wr_data_d;
            r_busy_q     <= w_busy_d;
            r_done_q     <= w_done_d;
            r_error_q    <= w_error_d;
`ifdef CSUM_EN
            r_csum_q     <= w_csum_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Expected memory writes
//                are queued as frames are driven and compared as wr_en fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam logic [31:0] c_BASE = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          last;
    } wr_exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    int          n_checks;
    int          n_fails;
    int          n_wr;
    wr_exp_t     exp_q[$];
    logic [31:0] fw[8];

    imem_loader #(
        .BASE_ADDR (c_BASE),
        .MAX_WORDS (16384)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", 64'd1, 64'd0);
            end else begin
                wr_exp_t e;
                e = exp_q.pop_front();
                check_eq("wr_addr", 64'(wr_addr), 64'(e.addr));
                check_eq("wr_data", 64'(wr_data), 64'(e.data));
                check_eq("in_ready_stall", 64'(in_ready), 64'd0);
`ifndef CSUM_EN
                if (e.last) begin
                    check_eq("done_with_last_wr", 64'(done), 64'd1);
                    check_eq("busy_with_last_wr", 64'(busy), 64'd0);
                end
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a byte and return once it has been consumed; in_valid stays high.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check_eq("ready_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Drive a well-formed frame of n words from fw[], queueing the expected writes.
    task automatic send_frame(input int n, input bit gaps);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        send_byte(8'hA5);
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        for (int k = 0; k < n; k++) begin
            wr_exp_t e;
            e.addr = c_BASE + 32'(4 * k);
            e.data = fw[k];
            e.last = (k == n - 1);
            exp_q.push_back(e);
            for (int i = 0; i < 4; i++) begin
                b  = fw[k][8*i +: 8];
                cs = cs ^ b;
                if (gaps && $urandom_range(0, 2) == 0) begin
                    idle_bus();
                    tick($urandom_range(1, 3));
                end
                send_byte(b);
            end
        end
`ifdef CSUM_EN
        send_byte(cs);
`endif
        idle_bus();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic bz);
        check_eq({tag, "_done"},  64'(done),  64'(d));
        check_eq({tag, "_error"}, 64'(error), 64'(e));
        check_eq({tag, "_busy"},  64'(busy),  64'(bz));
    endtask

    initial begin
        int wr0;
        n_checks = 0;
        n_fails  = 0;
        n_wr     = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // 1: reset state
        tick(2);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_wr_en",    64'(wr_en),    64'd0);
        check_eq("rst_wr_addr",  64'(wr_addr),  64'(c_BASE));
        check_eq("rst_wr_data",  64'(wr_data),  64'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0);

        // 2: two-word load, bytes held valid across the write stall
        wr0 = n_wr;
        fw[0] = 32'h0000_0013;
        fw[1] = 32'h0050_0093;
        send_byte(8'hA5);
        check_eq("busy_after_sync", 64'(busy), 64'd1);
        send_byte(8'h02);
        send_byte(8'h00);
        for (int k = 0; k < 2; k++) begin
            wr_exp_t e;
            e.addr = c_BASE + 32'(4 * k);
            e.data = fw[k];
            e.last = (k == 1);
            exp_q.push_back(e);
            for (int i = 0; i < 4; i++) send_byte(fw[k][8*i +: 8]);
        end
`ifdef CSUM_EN
        send_byte(8'hD0);
`endif
        idle_bus();
        tick(3);
        check_eq("load_writes", 64'(n_wr - wr0), 64'd2);
        check_status("load", 1'b1, 1'b0, 1'b0);

        // 3: garbage before the sync byte is ignored
        wr0 = n_wr;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        send_frame(2, 1'b0);
        tick(3);
        check_eq("resync_writes", 64'(n_wr - wr0), 64'd2);
        check_status("resync", 1'b1, 1'b0, 1'b0);

        // 4: oversize length (N = 0x4001)
        wr0 = n_wr;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h40);
        idle_bus();
        tick(3);
        check_eq("oversize_writes", 64'(n_wr - wr0), 64'd0);
        check_status("oversize", 1'b0, 1'b1, 1'b0);

        // Zero-length frame
        send_byte(8'hA5);
        check_eq("zero_err_cleared", 64'(error), 64'd0);
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef CSUM_EN
        send_byte(8'h00);
`endif
        idle_bus();
        tick(2);
        check_status("zero_len", 1'b1, 1'b0, 1'b0);

        // 5: reset mid-frame aborts without a write
        wr0 = n_wr;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        idle_bus();
        do_reset();
        tick(2);
        check_eq("abort_writes", 64'(n_wr - wr0), 64'd0);
        check_status("abort", 1'b0, 1'b0, 1'b0);
        fw[0] = 32'hDEAD_BEEF;
        send_frame(1, 1'b0);
        tick(3);
        check_eq("post_abort_writes", 64'(n_wr - wr0), 64'd1);
        check_status("post_abort", 1'b1, 1'b0, 1'b0);

        // Sync byte inside data is payload; random gaps in the stream
        for (int r = 0; r < 3; r++) begin
            wr0 = n_wr;
            fw[0] = 32'hA5A5_00A5;
            for (int k = 1; k < 5; k++) fw[k] = $urandom;
            send_frame(5, 1'b1);
            tick(3);
            check_eq("rand_writes", 64'(n_wr - wr0), 64'd5);
            check_status("rand", 1'b1, 1'b0, 1'b0);
        end

`ifdef CSUM_EN
        // 6: checksum mismatch still writes the word, then flags error
        foreach (fw[k]) fw[k] = 32'h0;
        for (int pass = 0; pass < 2; pass++) begin
            wr_exp_t e;
            wr0 = n_wr;
            e.addr = c_BASE;
            e.data = 32'h0000_0013;
            e.last = 1'b1;
            exp_q.push_back(e);
            send_byte(8'hA5);
            send_byte(8'h01);
            send_byte(8'h00);
            send_byte(8'h13);
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(pass == 0 ? 8'h12 : 8'h13);
            idle_bus();
            tick(3);
            check_eq("csum_writes", 64'(n_wr - wr0), 64'd1);
            if (pass == 0) check_status("csum_bad", 1'b0, 1'b1, 1'b0);
            else           check_status("csum_ok",  1'b1, 1'b0, 1'b0);
        end
`endif

        check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
